// File: rtl/weightbuffer_pkg.sv
// Shared types and geometry for the ping-pong ternary weight buffer.
package weightbuffer_pkg;

    localparam int unsigned N_I            = 512;
    localparam int unsigned WEIGHT_STAGGER = 2;
    localparam int unsigned K              = 3;
    localparam int unsigned WEIGHT_BITS    = 2;

    localparam int unsigned LANES         = N_I / WEIGHT_STAGGER;
    localparam int unsigned SLICE_W       = LANES * WEIGHT_BITS;
    localparam int unsigned TAPS          = K * K;
    localparam int unsigned BEATS_PER_SET = K * K * WEIGHT_STAGGER;
    localparam int unsigned CENTRE_TAP    = (K / 2) * K + (K / 2);
    localparam int unsigned RD_W          = BEATS_PER_SET * SLICE_W;

    typedef logic [WEIGHT_BITS-1:0] weight_t;
    typedef weight_t [LANES-1:0]    slice_t;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } load_state_e;

    // Index width for a counter over n entries, never narrower than one bit.
    function automatic int unsigned set_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned STAG_W = set_idx_w(WEIGHT_STAGGER);
    localparam int unsigned TAP_W  = set_idx_w(TAPS);

endpackage

// File: rtl/weightbuffer_if.sv
// Write stream from the weight streamer and read-set port towards the OCU array.
interface weightbuffer_if
    import weightbuffer_pkg::*;
#(
    parameter int unsigned N_SETS = 2
) ();
    localparam int unsigned SET_W = set_idx_w(N_SETS);
    localparam int unsigned CNT_W = $clog2(N_SETS + 1);

    logic             flush_i;
    logic             wr_valid_i;
    logic             wr_ready_o;
    slice_t           wr_data_i;
    logic             wr_k1_mode_i;
    logic             wr_set_done_o;
    logic             rd_valid_o;
    logic             rd_release_i;
    logic [SET_W-1:0] rd_set_o;
    logic [RD_W-1:0]  rd_data_o;
    logic [CNT_W-1:0] full_cnt_o;

    modport master (
        output flush_i, wr_valid_i, wr_data_i, wr_k1_mode_i, rd_release_i,
        input  wr_ready_o, wr_set_done_o, rd_valid_o, rd_set_o, rd_data_o, full_cnt_o
    );

    modport slave (
        input  flush_i, wr_valid_i, wr_data_i, wr_k1_mode_i, rd_release_i,
        output wr_ready_o, wr_set_done_o, rd_valid_o, rd_set_o, rd_data_o, full_cnt_o
    );
endinterface

// File: rtl/weightbuffer_load_ctrl.sv
// Load-side FSM: walks stagger/tap counters and steers each accepted beat to its slice.
module weightbuffer_load_ctrl
    import weightbuffer_pkg::*;
#(
    parameter int unsigned N_SETS = 2,
    parameter int unsigned SET_W  = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_fire,
    input  logic                     i_k1_mode,
    output logic [BEATS_PER_SET-1:0] o_slot_we_c,
    output logic                     o_zero_others_c,
    output logic                     o_last_c,
    output logic [SET_W-1:0]         o_wr_set,
    output logic                     o_set_done
);

    load_state_e       r_state;
    logic [STAG_W-1:0] r_stag;
    logic [TAP_W-1:0]  r_tap;
    logic              r_k1;
    logic [SET_W-1:0]  r_wr_set;
    logic              r_set_done;

    logic              w_k1;
    logic              w_stag_wrap;
    int unsigned       w_slot;

    // Mode comes straight from the input on a set's first beat, from the latch afterwards.
    always_comb begin
        w_k1            = (r_state == ST_IDLE) ? i_k1_mode : r_k1;
        w_stag_wrap     = (r_stag == STAG_W'(WEIGHT_STAGGER - 1));
        w_slot          = (w_k1 ? CENTRE_TAP : 32'(r_tap)) * WEIGHT_STAGGER + 32'(r_stag);
        o_last_c        = i_fire && w_stag_wrap && (w_k1 || (r_tap == TAP_W'(TAPS - 1)));
        o_zero_others_c = i_fire && (r_state == ST_IDLE) && i_k1_mode;
        o_slot_we_c     = '0;
        for (int unsigned s = 0; s < BEATS_PER_SET; s++) begin
            o_slot_we_c[s] = i_fire && (w_slot == s);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_state    <= ST_IDLE;
            r_stag     <= '0;
            r_tap      <= '0;
            r_k1       <= 1'b0;
            r_wr_set   <= '0;
            r_set_done <= 1'b0;
        end else begin
            r_set_done <= o_last_c;
            if (i_fire) begin
                r_k1 <= w_k1;
                if (o_last_c) begin
                    r_state  <= ST_IDLE;
                    r_stag   <= '0;
                    r_tap    <= '0;
                    r_wr_set <= (r_wr_set == SET_W'(N_SETS - 1)) ? '0 : r_wr_set + 1'b1;
                end else begin
                    r_state <= ST_FILL;
                    r_stag  <= w_stag_wrap ? '0 : r_stag + 1'b1;
                    if (w_stag_wrap) begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
            end
        end
    end

    assign o_wr_set   = r_wr_set;
    assign o_set_done = r_set_done;

endmodule

// File: rtl/weightbuffer_pingpong.sv
// Multi-set weight store: one set loads while a completed set is presented to the consumer.
module weightbuffer_pingpong
    import weightbuffer_pkg::*;
#(
    parameter int unsigned N_SETS = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    weightbuffer_if.slave  bus
);

    localparam int unsigned SET_W = set_idx_w(N_SETS);
    localparam int unsigned CNT_W = $clog2(N_SETS + 1);

    slice_t [BEATS_PER_SET-1:0] r_mem [N_SETS];
    logic [CNT_W-1:0]           r_full_cnt;
    logic [SET_W-1:0]           r_rd_set;
    logic                       r_wr_ready;
    logic                       r_rd_valid;

    logic [BEATS_PER_SET-1:0]   w_slot_we;
    logic                       w_zero_others;
    logic                       w_last;
    logic [SET_W-1:0]           w_wr_set;
    logic                       w_set_done;
    logic                       w_fire;
    logic                       w_rel;
    logic [CNT_W-1:0]           w_full_nxt;

    assign w_fire = bus.wr_valid_i && r_wr_ready && !bus.flush_i;
    assign w_rel  = bus.rd_release_i && r_rd_valid && !bus.flush_i;

    weightbuffer_load_ctrl #(
        .N_SETS (N_SETS),
        .SET_W  (SET_W)
    ) u_load_ctrl (
        .i_clk           (clk_i),
        .i_rst_n         (rst_ni),
        .i_flush         (bus.flush_i),
        .i_fire          (w_fire),
        .i_k1_mode       (bus.wr_k1_mode_i),
        .o_slot_we_c     (w_slot_we),
        .o_zero_others_c (w_zero_others),
        .o_last_c        (w_last),
        .o_wr_set        (w_wr_set),
        .o_set_done      (w_set_done)
    );

    // Slice storage; a 1x1 set clears every non-centre tap on its first beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < N_SETS; s++) begin
                r_mem[s] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < BEATS_PER_SET; b++) begin
                if (w_slot_we[b]) begin
                    r_mem[w_wr_set][b] <= bus.wr_data_i;
                end else if (w_zero_others && ((b / WEIGHT_STAGGER) != CENTRE_TAP)) begin
                    r_mem[w_wr_set][b] <= '0;
                end
            end
        end
    end

    // A completion and a release in the same cycle cancel out.
    always_comb begin
        w_full_nxt = r_full_cnt;
        if (w_last && !w_rel) begin
            w_full_nxt = r_full_cnt + 1'b1;
        end else if (!w_last && w_rel) begin
            w_full_nxt = r_full_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.flush_i) begin
            r_full_cnt <= '0;
            r_rd_set   <= '0;
            r_wr_ready <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            r_full_cnt <= w_full_nxt;
            r_wr_ready <= (w_full_nxt < CNT_W'(N_SETS));
            r_rd_valid <= (w_full_nxt != '0);
            if (w_rel) begin
                r_rd_set <= (r_rd_set == SET_W'(N_SETS - 1)) ? '0 : r_rd_set + 1'b1;
            end
        end
    end

    assign bus.wr_ready_o    = r_wr_ready;
    assign bus.wr_set_done_o = w_set_done;
    assign bus.rd_valid_o    = r_rd_valid;
    assign bus.rd_set_o      = r_rd_set;
    assign bus.full_cnt_o    = r_full_cnt;
    assign bus.rd_data_o     = r_rd_valid ? RD_W'(r_mem[r_rd_set]) : '0;

endmodule

// File: tb/tb_weightbuffer_pingpong.sv
// Directed + randomized bench for weightbuffer_pingpong (2-set and 3-set instances).
module tb_weightbuffer_pingpong;
    import weightbuffer_pkg::*;

    typedef logic [RD_W-1:0] img_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   sel   = 1'b0;
    logic   d_valid = 1'b0, d_mode = 1'b0, d_rel = 1'b0, d_flush = 1'b0;
    slice_t d_data  = '0;

    always #5 clk = ~clk;

    weightbuffer_if #(.N_SETS(2)) if2 ();
    weightbuffer_if #(.N_SETS(3)) if3 ();

    assign if2.wr_valid_i   = !sel && d_valid;
    assign if2.wr_data_i    = d_data;
    assign if2.wr_k1_mode_i = !sel && d_mode;
    assign if2.rd_release_i = !sel && d_rel;
    assign if2.flush_i      = !sel && d_flush;
    assign if3.wr_valid_i   = sel && d_valid;
    assign if3.wr_data_i    = d_data;
    assign if3.wr_k1_mode_i = sel && d_mode;
    assign if3.rd_release_i = sel && d_rel;
    assign if3.flush_i      = sel && d_flush;

    weightbuffer_pingpong #(.N_SETS(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));
    weightbuffer_pingpong #(.N_SETS(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3));

    logic        o_ready, o_valid, o_done;
    logic [31:0] o_set, o_full;
    img_t        o_data;
    assign o_ready = sel ? if3.wr_ready_o    : if2.wr_ready_o;
    assign o_valid = sel ? if3.rd_valid_o    : if2.rd_valid_o;
    assign o_done  = sel ? if3.wr_set_done_o : if2.wr_set_done_o;
    assign o_set   = sel ? 32'(if3.rd_set_o)   : 32'(if2.rd_set_o);
    assign o_full  = sel ? 32'(if3.full_cnt_o) : 32'(if2.full_cnt_o);
    assign o_data  = sel ? if3.rd_data_o     : if2.rd_data_o;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: completed sets as whole images in a FIFO, consumed in order.
    int    m_n;
    img_t  m_q[$];
    img_t  m_img;
    int    m_beat;
    bit    m_k1;
    int    m_rel;
    bit    m_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(input string tag, input img_t obs, input img_t exp);
        int bad;
        bad = 0;
        checks++;
        assert (obs === exp) else begin
            for (int b = BEATS_PER_SET - 1; b >= 0; b--) begin
                if (obs[b*SLICE_W +: SLICE_W] !== exp[b*SLICE_W +: SLICE_W]) bad = b;
            end
            errors++;
            $error("FAIL %s slot %0d got %h expected %h", tag, bad,
                   obs[bad*SLICE_W +: SLICE_W], exp[bad*SLICE_W +: SLICE_W]);
        end
    endtask

    function automatic slice_t rep32(input logic [31:0] w);
        return {(SLICE_W/32){w}};
    endfunction

    function automatic slice_t rnd_slice();
        slice_t s;
        for (int i = 0; i < int'(SLICE_W/32); i++) s[i*32 +: 32] = $urandom();
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_beat = 0;
        m_k1   = 1'b0;
        m_rel  = 0;
        m_done = 1'b0;
    endtask

    task automatic check_outputs();
        img_t exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : '0;
        chk({phase, ".ready"}, 64'(o_ready), 64'(m_q.size() < m_n));
        chk({phase, ".valid"}, 64'(o_valid), 64'(m_q.size() > 0));
        chk({phase, ".done"},  64'(o_done),  64'(m_done));
        chk({phase, ".rd_set"}, 64'(o_set),  64'(m_rel % m_n));
        chk({phase, ".full"},  64'(o_full),  64'(m_q.size()));
        chk_img({phase, ".data"}, o_data, exp_data);
    endtask

    // One clock: drive inputs, advance the model, then check all outputs after the edge.
    task automatic step(input bit v, input slice_t d, input bit md, input bit rel,
                        input bit fl, output bit acc);
        bit relok;
        int slot;
        d_valid = v; d_data = d; d_mode = md; d_rel = rel; d_flush = fl;
        acc    = 1'b0;
        m_done = 1'b0;
        if (fl) begin
            model_reset();
        end else begin
            acc   = v && (m_q.size() < m_n);
            relok = rel && (m_q.size() > 0);
            if (relok) begin
                void'(m_q.pop_front());
                m_rel++;
            end
            if (acc) begin
                if (m_beat == 0) begin
                    m_k1 = md;
                    if (md) m_img = '0;
                end
                slot = m_k1 ? int'(CENTRE_TAP * WEIGHT_STAGGER) + m_beat : m_beat;
                m_img[slot*SLICE_W +: SLICE_W] = d;
                m_beat++;
                if (m_beat == int'(m_k1 ? WEIGHT_STAGGER : BEATS_PER_SET)) begin
                    m_q.push_back(m_img);
                    m_beat = 0;
                    m_done = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        d_valid = 1'b0; d_rel = 1'b0; d_flush = 1'b0; d_mode = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_outputs();
        rst_n = 1'b1;
    endtask

    // Streamer must hold data while a beat is stalled.
    slice_t hold_d;
    bit     hold_p = 1'b0;
    always @(posedge clk) begin
        if (hold_p && d_valid && !d_flush) begin
            checks++;
            assert (d_data === hold_d) else begin
                errors++;
                $error("FAIL stable_data got %h expected %h", d_data[31:0], hold_d[31:0]);
            end
        end
        hold_p <= d_valid && !o_ready && !d_flush && rst_n;
        hold_d <= d_data;
    end

    initial begin
        bit     acc, v, r, curmode;
        slice_t cur, s55;
        img_t   e;
        int     guard, loaded, rels;

        m_n   = 2;
        phase = "reset";
        do_reset();

        phase = "basic";
        for (int i = 0; i < int'(BEATS_PER_SET); i++) begin
            step(1'b1, rep32(32'(i)), 1'b0, 1'b0, 1'b0, acc);
            if (i == int'(BEATS_PER_SET) - 2) chk("basic.no_early_done", 64'(o_done), 64'd0);
        end
        chk("basic.done_last", 64'(o_done), 64'd1);
        chk("basic.valid_next", 64'(o_valid), 64'd1);
        e = '0;
        for (int k1 = 0; k1 < int'(K); k1++)
            for (int k2 = 0; k2 < int'(K); k2++)
                for (int s = 0; s < int'(WEIGHT_STAGGER); s++)
                    e[((k1*K + k2)*WEIGHT_STAGGER + s)*SLICE_W +: SLICE_W] =
                        rep32(32'((k1*3 + k2)*2 + s));
        chk_img("basic.layout", o_data, e);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        chk("basic.done_pulse_width", 64'(o_done), 64'd0);

        phase = "bp";
        for (int i = 0; i < int'(BEATS_PER_SET); i++) step(1'b1, '1, 1'b0, 1'b0, 1'b0, acc);
        chk("bp.full", 64'(o_full), 64'd2);
        chk("bp.not_ready", 64'(o_ready), 64'd0);
        cur = rnd_slice();
        for (int i = 0; i < 3; i++) step(1'b1, cur, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, cur, 1'b0, 1'b1, 1'b0, acc);
        chk("bp.ready_after_release", 64'(o_ready), 64'd1);
        chk("bp.rd_set", 64'(o_set), 64'd1);

        phase = "simul";
        guard = 0;
        for (int i = 0; i < int'(BEATS_PER_SET) && guard < 100; guard++) begin
            step(1'b1, cur, 1'b0, i == int'(BEATS_PER_SET) - 1, 1'b0, acc);
            if (acc) begin
                i++;
                cur = rnd_slice();
            end
        end
        chk("simul.full_unchanged", 64'(o_full), 64'd1);
        chk("simul.rd_set", 64'(o_set), 64'd0);

        phase = "k1";
        s55 = rep32(32'h5555_5555);
        step(1'b1, s55, 1'b1, 1'b0, 1'b0, acc);
        chk("k1.no_done_beat0", 64'(o_done), 64'd0);
        step(1'b1, s55, 1'b0, 1'b0, 1'b0, acc);
        chk("k1.done_beat1", 64'(o_done), 64'd1);
        chk("k1.full", 64'(o_full), 64'd2);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        e = '0;
        e[(4*2 + 0)*SLICE_W +: SLICE_W] = s55;
        e[(4*2 + 1)*SLICE_W +: SLICE_W] = s55;
        chk_img("k1.image", o_data, e);
        chk("k1.rd_set", 64'(o_set), 64'd1);

        phase = "flush";
        for (int i = 0; i < 7; i++) step(1'b1, rnd_slice(), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, rnd_slice(), 1'b0, 1'b1, 1'b1, acc);
        chk("flush.valid", 64'(o_valid), 64'd0);
        chk("flush.full", 64'(o_full), 64'd0);
        chk("flush.rd_set", 64'(o_set), 64'd0);
        chk("flush.ready", 64'(o_ready), 64'd1);
        chk("flush.data_zero", o_data[63:0], 64'd0);
        for (int i = 0; i < int'(BEATS_PER_SET); i++) begin
            step(1'b1, rep32(32'(100 + i)), 1'b0, 1'b0, 1'b0, acc);
            if (i == int'(BEATS_PER_SET) - 2) chk("flush.valid_before_last", 64'(o_valid), 64'd0);
        end
        chk("flush.valid_after_last", 64'(o_valid), 64'd1);
        chk("flush.slot0", o_data[63:0], {32'd100, 32'd100});

        phase = "n3";
        sel = 1'b1;
        m_n = 3;
        do_reset();
        cur     = rnd_slice();
        curmode = ($urandom_range(3) == 0);
        guard = 0; loaded = 0; rels = 0;
        while (rels < 7 && guard < 4000) begin
            guard++;
            v = (loaded < 7) && ($urandom_range(3) != 0);
            r = ($urandom_range(2) == 0) && (m_q.size() > 0);
            if (r) begin
                chk("n3.rd_set_seq", 64'(o_set), 64'(rels % 3));
                rels++;
            end
            step(v, cur, curmode, r, 1'b0, acc);
            if (m_done) loaded++;
            if (acc) begin
                cur = rnd_slice();
                if (m_beat == 0) curmode = ($urandom_range(3) == 0);
            end
        end
        chk("n3.releases", 64'(rels), 64'd7);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        chk("n3.drained", 64'(o_full), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
